// File: rtl/fa_resp_checker.sv
// Full-adder response checker: compares DUT sum/cout against a reference adder over a run of NUM_VEC vectors.
// Optional coverage map/full outputs are built when FA_CHK_COVER_EN is defined.
module fa_ref (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (b & c) | (a & c);
endmodule

module fa_resp_checker #(
  parameter int NUM_VEC = 8,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       vec_count,
  output logic [2:0]       first_err_vec,
  output logic             err_flag
`ifdef FA_CHK_COVER_EN
  ,
  output logic [7:0]       cover_map,
  output logic             cover_full
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic exp_sum, exp_cout;
  logic accept, mismatch, start_run, last_vec;

  fa_ref u_ref (
    .a    (a),
    .b    (b),
    .c    (c),
    .sum  (exp_sum),
    .cout (exp_cout)
  );

  // start only opens a run outside CHECK; a vector arriving with it is dropped
  assign start_run = start && (state != CHECK);
  assign accept    = (state == CHECK) && in_valid;
  assign mismatch  = accept && ((sum != exp_sum) || (cout != exp_cout));
  assign last_vec  = (vec_count == 8'(NUM_VEC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (accept && last_vec) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = CHECK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count     <= '0;
      vec_count     <= '0;
      first_err_vec <= '0;
      err_flag      <= 1'b0;
    end else begin
      err_flag <= mismatch;
      if (start_run) begin
        err_count     <= '0;
        vec_count     <= '0;
        first_err_vec <= '0;
      end else if (accept) begin
        vec_count <= vec_count + 8'd1;
        if (mismatch) begin
          // err_count never wraps, so zero reliably marks the first miss of a run
          if (err_count == '0) first_err_vec <= {a, b, c};
          if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        end
      end
    end
  end

`ifdef FA_CHK_COVER_EN
  always_ff @(posedge clk) begin
    if (rst || start_run) cover_map <= '0;
    else if (accept)      cover_map[{a, b, c}] <= 1'b1;
  end

  assign cover_full = &cover_map;
  assign pass       = done && (err_count == '0) && cover_full;
`else
  assign pass       = done && (err_count == '0);
`endif

endmodule
